cmp_nibble_scheduler: RTL and testbench
=======================================

# cmp_nibble_scheduler

Shares one 4-bit low-power magnitude comparator among several requesters that need to compare wider operands. A round-robin arbiter accepts one request at a time. The operands are latched and presented to the comparator one nibble per cycle, MSB nibble first, and the sequence stops at the first unequal nibble. The block owns the comparator's inputs and enable, so the comparator toggles only while a compare is in progress.

## Interface
- W, 16, operand width in bits; multiple of 4, 4..32; NNIB = W/4
- NREQ, 2, number of requesters, 2..4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept strobe, combinational
- req_a  in  NREQ*W  flattened operand A; requester i at [i*W +: W]
- req_b  in  NREQ*W  flattened operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  clog2(NREQ)  index of the requester the result belongs to
- rsp_gt / rsp_lt / rsp_eq  out  1 each  A>B / A<B / A==B, unsigned
- rsp_err  out  1  comparator returned a non-one-hot result
- cmp_en  out  1  comparator enable; high only in CMP
- cmp_a, cmp_b  out  4 each  nibble driven to the comparator
- cmp_agt, cmp_alt, cmp_aeq  in  1 each  combinational comparator result for the current cmp_a/cmp_b

## Operation
- FSM states: IDLE, CMP, RESP. Reset state is IDLE.
- IDLE
  - If any req_valid is high, grant round-robin starting at (last_grant+1) mod NREQ.
  - Assert req_ready for the granted requester in that same cycle.
  - Latch its A and B, set rsp_id = grant, set nib = NNIB-1, update last_grant, go to CMP.
- CMP
  - cmp_en = 1; cmp_a = A[nib*4 +: 4]; cmp_b = B[nib*4 +: 4].
  - At each clock edge, sample {cmp_agt, cmp_alt, cmp_aeq}.
  - If the sample is not one-hot: latch rsp_err = 1, clear gt/lt/eq, go to RESP.
  - Else if gt or lt: latch that flag, go to RESP (early exit).
  - Else if nib == 0: latch eq, go to RESP.
  - Else: decrement nib and stay in CMP.
- RESP
  - rsp_valid = 1. All rsp_* outputs stay stable until rsp_valid && rsp_ready, then go to IDLE.
  - No request is accepted while in CMP or RESP.
- Outside CMP, cmp_a and cmp_b are held at 4'h0 and cmp_en = 0. This is the low-power rule: no comparator activity while idle.
- Result flags are one-hot across {gt, lt, eq, err} whenever rsp_valid = 1.
- Compare semantics are unsigned over all W bits.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_gt/lt/eq/err = 0, cmp_en = 0, cmp_a = cmp_b = 0, last_grant = NREQ-1. Requester 0 therefore wins first.
- Accept occurs in cycle t (req_valid[i] && req_ready[i]).
- CMP occupies cycles t+1 .. t+k.
  - k = 1 + the number of equal leading nibbles before the first difference.
  - k = NNIB when the operands are equal.
- rsp_valid rises at cycle t+k+1.
  - Best-case latency: 2 cycles.
  - Worst-case latency: NNIB+1 cycles.
- After the response handshake there is one IDLE cycle before the next accept. Minimum period per compare is k+2 cycles plus any rsp_ready stall.
- Requesters must hold req_valid and operands stable until accepted. After acceptance the operands may change; the block uses its latched copy.
- Simultaneous requests are resolved by the round-robin pointer only. A requester that drops req_valid before grant loses its turn and receives no result.
- Asserting rst_n low in any state:
  - immediately clears all outputs and returns the FSM to IDLE;
  - drops any in-flight compare with no response;
  - resets the pointer so requester 0 has priority.
- Comparator combinational delay must settle within one clk period. The block adds no wait states.

## Test plan (W=16, NREQ=2)
- Reset: hold rst_n low with req_valid=2'b11 -> all outputs 0, req_ready=0. After release, the first grant goes to requester 0.
- Equal operands: req0 A=16'h1234, B=16'h1234 -> cmp_a sequence 1,2,3,4 over 4 cycles; rsp_valid at t+5 with rsp_eq=1, rsp_id=0.
- Early exit: req1 A=16'h8000, B=16'h7FFF -> a single CMP cycle (cmp_a=8, cmp_b=7); rsp_gt=1, rsp_id=1 at t+2. Also A=16'h12F0, B=16'h1300 -> rsp_lt=1 at t+3.
- Fairness and back-pressure:
  - Both requesters continuously valid -> grants alternate 0,1,0,1.
  - Hold rsp_ready low for 3 cycles -> rsp_* stay stable, no req_ready pulse, cmp_en=0, cmp_a=cmp_b=0.
- Reset mid-compare: deassert rst_n in the second CMP cycle of A=16'h1111, B=16'h1112 -> outputs clear asynchronously and no response is issued. After release, the next grant goes to req0.
- Comparator fault: force cmp_agt=cmp_aeq=1 in the first CMP cycle -> rsp_err=1, gt/lt/eq=0, rsp_valid at t+2.

Source files
------------

// File: rtl/cmp_nibble_scheduler_if.sv
// cmp_nibble_scheduler_if
//   Request/response bundle between the requesters and the shared
//   nibble-serial comparator scheduler.
//   master : requester side (drives req_valid/req_a/req_b, rsp_ready)
//   slave  : scheduler side (drives req_ready and the rsp_* result)
interface cmp_nibble_scheduler_if #(
  parameter int W    = 16,
  parameter int NREQ = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_gt;
  logic              rsp_lt;
  logic              rsp_eq;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_err
  );
endinterface

// File: rtl/cmp_nibble_scheduler.sv
// cmp_nibble_scheduler
//   Shares one 4-bit magnitude comparator among NREQ requesters comparing
//   W-bit unsigned operands. One request is granted round-robin, its operands
//   are latched and fed to the comparator MSB nibble first; the walk stops at
//   the first unequal nibble. The comparator inputs and enable are only
//   active while a compare is in progress.
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : req_valid/req_ready/req_a/req_b, rsp_valid/rsp_ready,
//                        rsp_id, rsp_gt/lt/eq/err
//   cmp_en, cmp_a/b    : enable and nibble operands driven to the comparator
//   cmp_agt/alt/aeq    : comparator result for the current cmp_a/cmp_b
//
// state | meaning
// IDLE  | waiting for a request; grants round-robin, req_ready combinational
// CMP   | one nibble per cycle on the comparator, MSB first
// RESP  | result held on rsp_* until rsp_ready
module cmp_nibble_scheduler #(
  parameter int W    = 16,
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmp_nibble_scheduler_if.slave bus,
  output logic                  cmp_en,
  output logic [3:0]            cmp_a,
  output logic [3:0]            cmp_b,
  input  logic                  cmp_agt,
  input  logic                  cmp_alt,
  input  logic                  cmp_aeq
);
  localparam int NNIB = W / 4;
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NBW  = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state;
  logic [W-1:0]    a_q, b_q;
  logic [NBW-1:0]  nib;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q, gt_q, lt_q, eq_q, err_q;

  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic            cmp_onehot;
  logic            cmp_done;

  function automatic logic [3:0] nibble(input logic [W-1:0] v, input int n);
    return v[n*4 +: 4];
  endfunction

  // Round-robin search starting just after the last grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!gnt_any && bus.req_valid[(int'(last_grant) + off) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(last_grant) + off) % NREQ);
      end
    end
  end

  assign sel_a = bus.req_a[int'(gnt_idx)*W +: W];
  assign sel_b = bus.req_b[int'(gnt_idx)*W +: W];

  // Gated by rst_n so requesters never see an accept while reset is held.
  assign bus.req_ready = (state == IDLE && rst_n && gnt_any) ?
                         (NREQ'(1) << gnt_idx) : '0;

  assign cmp_onehot = ({cmp_agt, cmp_alt, cmp_aeq} == 3'b100) ||
                      ({cmp_agt, cmp_alt, cmp_aeq} == 3'b010) ||
                      ({cmp_agt, cmp_alt, cmp_aeq} == 3'b001);
  assign cmp_done   = !cmp_onehot || cmp_agt || cmp_alt || (nib == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      nib         <= '0;
      last_grant  <= IDW'(NREQ - 1);
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
      cmp_en      <= 1'b0;
      cmp_a       <= 4'h0;
      cmp_b       <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            rsp_id_q   <= gnt_idx;
            last_grant <= gnt_idx;
            nib        <= NBW'(NNIB - 1);
            // Comparator inputs are registered so they are valid for the
            // whole first CMP cycle.
            cmp_en     <= 1'b1;
            cmp_a      <= nibble(sel_a, NNIB - 1);
            cmp_b      <= nibble(sel_b, NNIB - 1);
            state      <= CMP;
          end
        end
        CMP: begin
          if (cmp_done) begin
            // A non-one-hot sample reports only err; otherwise exactly one
            // of gt/lt/eq is set (eq only reachable on the last nibble).
            err_q       <= !cmp_onehot;
            gt_q        <= cmp_onehot && cmp_agt;
            lt_q        <= cmp_onehot && cmp_alt;
            eq_q        <= cmp_onehot && cmp_aeq;
            rsp_valid_q <= 1'b1;
            cmp_en      <= 1'b0;
            cmp_a       <= 4'h0;
            cmp_b       <= 4'h0;
            state       <= RESP;
          end else begin
            nib   <= nib - 1'b1;
            cmp_a <= nibble(a_q, int'(nib) - 1);
            cmp_b <= nibble(b_q, int'(nib) - 1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            err_q       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_gt    = gt_q;
  assign bus.rsp_lt    = lt_q;
  assign bus.rsp_eq    = eq_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_cmp_nibble_scheduler.sv
// tb_cmp_nibble_scheduler
//   Scoreboard bench for cmp_nibble_scheduler (W=16, NREQ=2). Accepts seen on
//   the bus push the expected result (computed with plain arithmetic) into a
//   queue; a negedge monitor checks grants, comparator activity, response
//   latency and response fields, and pops on the response handshake.
module tb_cmp_nibble_scheduler;
  localparam int W    = 16;
  localparam int NREQ = 2;
  localparam int NNIB = W / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmp_en;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_agt, cmp_alt, cmp_aeq;
  bit         fault = 1'b0;

  logic [NREQ-1:0] rv = '0;
  logic [W-1:0]    ra [NREQ];
  logic [W-1:0]    rb [NREQ];
  logic            rr_in = 1'b1;

  cmp_nibble_scheduler_if #(.W(W), .NREQ(NREQ)) bus ();

  assign bus.req_valid = rv;
  assign bus.req_a     = {ra[1], ra[0]};
  assign bus.req_b     = {rb[1], rb[0]};
  assign bus.rsp_ready = rr_in;

  cmp_nibble_scheduler #(.W(W), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cmp_en  (cmp_en),
    .cmp_a   (cmp_a),
    .cmp_b   (cmp_b),
    .cmp_agt (cmp_agt),
    .cmp_alt (cmp_alt),
    .cmp_aeq (cmp_aeq)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit comparator, with an optional stuck fault (gt and eq).
  always_comb begin
    cmp_agt = (cmp_a > cmp_b);
    cmp_alt = (cmp_a < cmp_b);
    cmp_aeq = (cmp_a == cmp_b);
    if (fault && cmp_en) begin
      cmp_agt = 1'b1;
      cmp_alt = 1'b0;
      cmp_aeq = 1'b1;
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           id;
    bit           gt, lt, eq, err;
    int           tacc;
    int           k;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   busy = 1'b0;
  int   rr_last = NREQ - 1;
  int   n_acc = 0;
  int   last_acc = 0;
  int   n_resp = 0;
  int   mode = 0;
  bit [NREQ-1:0] acc_flag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Cycles spent in CMP: one per nibble down to and including the first
  // differing one, all of them when equal.
  function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a ^ b;
    if (d == '0) return NNIB;
    for (int p = W - 1; p >= 0; p--)
      if (d[p]) return NNIB - p / 4;
    return NNIB;
  endfunction

  // Nibble on the comparator in the j-th CMP cycle (j = 1 is the MSB nibble).
  function automatic logic [3:0] nib_at(input logic [W-1:0] v, input int j);
    return 4'(v >> (W - 4 * j));
  endfunction

  function automatic logic [W-1:0] rnd_b(input logic [W-1:0] a);
    case ($urandom_range(0, 3))
      0:       return a;
      1:       return W'($urandom);
      2:       return a ^ (W'(1) << $urandom_range(0, W - 1));
      default: return {a[W-1:4], 4'($urandom)};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int   eid;
    int   obs;
    int   j;
    bit   incmp;
    bit   ev;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      busy    = 1'b0;
      rr_last = NREQ - 1;
    end else begin
      // Grant / accept.
      if (!busy) begin
        if (bus.req_valid != '0) begin
          eid = -1;
          for (int off = 1; off <= NREQ; off++)
            if (eid < 0 && bus.req_valid[(rr_last + off) % NREQ]) eid = (rr_last + off) % NREQ;
          chk("grant", 64'(bus.req_ready), 64'(1 << eid));
          obs = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : -1;
          glog.push_back(obs);
          e.a  = ra[eid];
          e.b  = rb[eid];
          e.id = eid;
          if (fault) begin
            e.gt = 1'b0; e.lt = 1'b0; e.eq = 1'b0; e.err = 1'b1; e.k = 1;
          end else begin
            e.gt = (e.a > e.b); e.lt = (e.a < e.b); e.eq = (e.a == e.b); e.err = 1'b0;
            e.k  = ref_k(e.a, e.b);
          end
          e.tacc = cyc;
          sb.push_back(e);
          busy        = 1'b1;
          rr_last     = eid;
          acc_flag[eid] = 1'b1;
          n_acc++;
          last_acc = cyc;
        end
      end else begin
        chk("ready_while_busy", 64'(bus.req_ready), 64'(0));
      end
      // Comparator activity.
      if (sb.size() > 0) begin
        j     = cyc - sb[0].tacc;
        incmp = (j >= 1 && j <= sb[0].k);
        chk("cmp_en", 64'(cmp_en), 64'(incmp));
        chk("cmp_a", 64'(cmp_a), incmp ? 64'(nib_at(sb[0].a, j)) : 64'(0));
        chk("cmp_b", 64'(cmp_b), incmp ? 64'(nib_at(sb[0].b, j)) : 64'(0));
      end else begin
        chk("cmp_en_idle", 64'(cmp_en), 64'(0));
        chk("cmp_ab_idle", 64'({cmp_a, cmp_b}), 64'(0));
      end
      // Response.
      if (sb.size() > 0) begin
        ev = (cyc >= sb[0].tacc + sb[0].k + 1);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        if (bus.rsp_valid) begin
          chk("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
          chk("rsp_flags", 64'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq, bus.rsp_err}),
              64'({sb[0].gt, sb[0].lt, sb[0].eq, sb[0].err}));
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            busy = 1'b0;
            n_resp++;
          end
        end
      end else begin
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (mode == 1) begin
          ra[i] = W'($urandom);
          rb[i] = rnd_b(ra[i]);
        end else begin
          rv[i] = 1'b0;
        end
      end
    end
    if (mode == 2) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = W'($urandom);
          rb[i] = rnd_b(ra[i]);
        end
      end
    end
    if (mode != 0) rr_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    rv[i] = 1'b1;
    ra[i] = a;
    rb[i] = b;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rv != '0 || busy || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_done"}, 64'(n < 200), 64'(1));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
    chk({tag, "_rsp_flags"}, 64'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq, bus.rsp_err}), 64'(0));
    chk({tag, "_cmp"}, 64'({cmp_en, cmp_a, cmp_b}), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int g0;
    ra[0] = 16'h1234; rb[0] = 16'h1234;
    ra[1] = 16'h8000; rb[1] = 16'h7FFF;
    rv    = 2'b11;
    rr_in = 1'b1;

    // Reset held with both requesting: everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // req0 equal (4 CMP cycles, eq) then req1 8000/7FFF (1 CMP cycle, gt).
    drain("eq_gt");
    chk("first_grant", 64'(glog[0]), 64'(0));

    // 12F0 vs 1300 -> lt after 2 CMP cycles, with rsp_ready stalled.
    rr_in = 1'b0;
    issue(1, 16'h12F0, 16'h1300);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("stall_rsp_seen", 64'(n < 50), 64'(1));
    issue(0, 16'hBEEF, 16'hBEE0);
    repeat (3) tick();
    rr_in = 1'b1;
    drain("lt_stall");

    // Comparator returns a non-one-hot result in the first CMP cycle.
    fault = 1'b1;
    issue(0, 16'hABCD, 16'hABCD);
    drain("fault");
    fault = 1'b0;

    // Reset in the second CMP cycle of 1111 vs 1112.
    g0 = n_acc;
    issue(0, 16'h1111, 16'h1112);
    n = 0;
    while (n_acc == g0 && n < 50) begin
      tick();
      n++;
    end
    chk("midrst_accept", 64'(n_acc > g0), 64'(1));
    while (cyc < last_acc + 2) tick();
    chk("midrst_cmp_active", 64'(cmp_en), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrst");
    issue(0, W'($urandom), W'($urandom));
    issue(1, W'($urandom), W'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_held_ready", 64'(bus.req_ready), 64'(0));
    g0    = glog.size();
    rst_n = 1'b1;
    drain("post_reset");
    chk("post_reset_grant", 64'(glog[g0]), 64'(0));

    // Both requesters continuously valid: grants alternate.
    mode = 1;
    g0   = glog.size();
    for (int i = 0; i < NREQ; i++) issue(i, W'($urandom), W'($urandom));
    n = 0;
    while (glog.size() < g0 + 12 && n < 400) begin
      tick();
      n++;
    end
    mode  = 0;
    rr_in = 1'b1;
    drain("fair");
    chk("fair_count", 64'(glog.size() >= g0 + 12), 64'(1));
    for (int i = g0 + 1; i < g0 + 12; i++)
      chk("fair_alternate", 64'(glog[i]), 64'(glog[i-1] ^ 1));

    // Random traffic and random back-pressure.
    mode = 2;
    repeat (400) tick();
    mode  = 0;
    rr_in = 1'b1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
